// File: rtl/serial_frame_rx_pkg.sv
// Shared encodings for the serial frame receiver: FSM states, line levels, counter sizing.
package serial_frame_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_STOP   = 2'd2,
    ST_PARITY = 2'd3
  } state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = LINE_IDLE;

  // Counter only has to reach WIDTH-1 for the largest supported WIDTH.
  localparam int MAX_WIDTH = 16;
  localparam int CNT_W     = $clog2(MAX_WIDTH);

endpackage

// File: rtl/serial_frame_rx_sipo_shift_reg.sv
// Serial-in parallel-out register, LSB-first fill: after WIDTH shifts the first bit sits in dat[0].
// One cycle per shift; no flow control, contents are don't-care when not shifting.
module sipo_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] dat
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (shift_en) sr_d = {sin, sr_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

  assign dat = sr_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Start/data/stop serial frame receiver; valid pulses WIDTH+1 clocks after the start-bit sample (+1 with parity).
// No backpressure: every good frame is delivered; SERIAL_FRAME_RX_PARITY_EN adds an even-parity bit and parity_err.
module serial_frame_rx
  import serial_frame_rx_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             r,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             frame_err,
`ifdef SERIAL_FRAME_RX_PARITY_EN
  output logic             parity_err,
`endif
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             shift_en;
  logic [WIDTH-1:0] sr_dat;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic             parity_bad_q, parity_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  sipo_shift_reg #(.WIDTH(WIDTH)) u_sipo (
    .clk      (clk),
    .shift_en (shift_en),
    .sin      (sin),
    .dat      (sr_dat)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    shift_en    = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sin == LINE_START) begin
          state_d = ST_DATA;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_STOP;
`endif
        end
      end
`ifdef SERIAL_FRAME_RX_PARITY_EN
      ST_PARITY: begin
        // Even parity: data bits plus parity bit must XOR to zero.
        parity_bad_d = ^{sr_dat, sin};
        state_d      = ST_STOP;
      end
`endif
      ST_STOP: begin
        state_d     = ST_IDLE;
        frame_err_d = (sin != LINE_STOP);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        parity_err_d = parity_bad_q;
        if (sin == LINE_STOP && !parity_bad_q) begin
`else
        if (sin == LINE_STOP) begin
`endif
          q_d     = sr_dat;
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!r) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      q_q         <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign q         = q_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);
`ifdef SERIAL_FRAME_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx (WIDTH=8); parity steps compile in with SERIAL_FRAME_RX_PARITY_EN.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       r;
  logic       sin;
  logic [7:0] q;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic       parity_err;
  localparam int FRAME_LEN = 11;
`else
  localparam int FRAME_LEN = 10;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int first_done = 0;

  serial_frame_rx #(.WIDTH(8)) dut (
    .clk       (clk),
    .r         (r),
    .sin       (sin),
    .q         (q),
    .valid     (valid),
    .frame_err (frame_err),
`ifdef SERIAL_FRAME_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one line bit, let one rising edge sample it, then settle before checking.
  task automatic step(input logic b);
    sin = b;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Start bit plus eight data bits LSB first; no pulse may appear mid-frame.
  task automatic send_head(input logic [7:0] d);
    step(1'b0);
    start_cyc = cyc;
    chk("busy_after_start", busy, 1);
    chk("valid_after_start", valid, 0);
    chk("ferr_after_start", frame_err, 0);
    for (int i = 0; i < 8; i++) begin
      step(d[i]);
      chk("valid_mid", valid, 0);
      chk("ferr_mid", frame_err, 0);
      chk("busy_mid", busy, 1);
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic stop);
    send_head(d);
`ifdef SERIAL_FRAME_RX_PARITY_EN
    step(^d);
    chk("valid_par", valid, 0);
`endif
    step(stop);
    done_cyc = cyc;
  endtask

  initial begin
    r   = 1'b0;
    sin = 1'b1;
    step(1'b1);
    step(1'b1);
    chk("rst_q", q, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_busy", busy, 0);

    r = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      chk("idle_valid", valid, 0);
      chk("idle_ferr", frame_err, 0);
      chk("idle_busy", busy, 0);
    end
    chk("idle_q", q, 8'h00);

    frame(8'hA5, 1'b1);
    chk("a5_valid", valid, 1);
    chk("a5_q", q, 8'hA5);
    chk("a5_ferr", frame_err, 0);
    chk("a5_busy", busy, 0);
    chk("a5_latency", done_cyc - start_cyc, FRAME_LEN - 1);
    step(1'b1);
    chk("a5_valid_drop", valid, 0);
    chk("a5_q_hold", q, 8'hA5);

    frame(8'h3C, 1'b0);
    chk("3c_ferr", frame_err, 1);
    chk("3c_valid", valid, 0);
    chk("3c_q_keep", q, 8'hA5);

    // Start bit right after a framing error, then a second frame with no idle gap.
    frame(8'h01, 1'b1);
    first_done = done_cyc;
    chk("b2b1_valid", valid, 1);
    chk("b2b1_q", q, 8'h01);
    frame(8'hFF, 1'b1);
    chk("b2b2_valid", valid, 1);
    chk("b2b2_q", q, 8'hFF);
    chk("b2b_spacing", done_cyc - first_done, FRAME_LEN);
    step(1'b1);
    chk("b2b2_valid_drop", valid, 0);

    // 0x5A LSB first: 0,1,0,1,... reset lands on the 4th data bit.
    step(1'b0);
    step(1'b0);
    step(1'b1);
    step(1'b0);
    r = 1'b0;
    step(1'b1);
    chk("mrst_q", q, 8'h00);
    chk("mrst_valid", valid, 0);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_busy", busy, 0);
    step(1'b1);
    r = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1'b1);
      chk("post_rst_valid", valid, 0);
      chk("post_rst_ferr", frame_err, 0);
    end
    frame(8'h5A, 1'b1);
    chk("5a_valid", valid, 1);
    chk("5a_q", q, 8'h5A);
    chk("5a_ferr", frame_err, 0);
    step(1'b1);

`ifdef SERIAL_FRAME_RX_PARITY_EN
    send_head(8'h07);
    step(1'b1);
    step(1'b1);
    chk("p07_valid", valid, 1);
    chk("p07_q", q, 8'h07);
    chk("p07_perr", parity_err, 0);
    step(1'b1);
    send_head(8'h0F);
    step(1'b1);
    step(1'b1);
    chk("p0f_bad_valid", valid, 0);
    chk("p0f_bad_perr", parity_err, 1);
    chk("p0f_bad_q", q, 8'h07);
    step(1'b1);
    chk("perr_drop", parity_err, 0);
    send_head(8'h07);
    step(1'b0);
    step(1'b0);
    chk("pboth_perr", parity_err, 1);
    chk("pboth_ferr", frame_err, 1);
    chk("pboth_valid", valid, 0);
    chk("pboth_q", q, 8'h07);
    step(1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Serial-to-parallel frame receiver: the receiving end of the team's shift-register serial link. It takes a one-bit-per-clock serial line framed as start bit, WIDTH data bits LSB first, and stop bit, and presents the data word in parallel with a one-cycle valid strobe. It sits downstream of the parallel-in/serial-out transmitter chain, on the same clock, and flags malformed frames instead of delivering them.

## Interface
- WIDTH, 8: data bits per frame, 2..16.
- clk  input  1  clock; all state changes on its rising edge.
- r  input  1  reset; synchronous, active-low.
- sin  input  1  serial line; idles high (1), start bit 0, stop bit 1.
- q  output  WIDTH  last correctly received word; holds until the next good frame.
- valid  output  1  one-cycle pulse; q updated with a good frame this cycle.
- frame_err  output  1  one-cycle pulse; stop bit sampled as 0.
- busy  output  1  high while a frame is in progress (any state except IDLE).

## Operation
- One sample per clock, no oversampling; sin is synchronous to clk.
- States: IDLE, DATA, STOP (plus PARITY when configured).
- IDLE: sin=0 -> DATA, bit counter cleared. sin=1 -> stay.
- DATA: shift sin into shift register, LSB first (first data bit lands in q[0]); counter increments; after the WIDTH-th bit -> STOP.
- STOP: sin=1 -> q loaded from shift register, valid=1. sin=0 -> frame_err=1, q unchanged. Either case -> IDLE.
- Back-to-back frames: IDLE in the cycle after STOP may accept a new start bit immediately; minimum frame period WIDTH+2 cycles.
- valid and frame_err are never high together; both are registered outputs.
- Shift register content is don't-care outside DATA; only q is architecturally visible.
- Reset (r=0 at an edge), including mid-frame: state IDLE, counter 0, shift register discarded, q=0, valid=0, frame_err=0, busy=0. An in-flight frame is lost without any error pulse.

## Timing
- Edge E0 samples start bit; edges E1..E(WIDTH) sample data; edge E(WIDTH+1) samples stop.
- q/valid/frame_err update at E(WIDTH+1) and are visible in the following cycle; valid/frame_err drop at E(WIDTH+2).
- Latency from start-bit sample to valid: WIDTH+1 clocks (WIDTH+2 with parity).
- busy rises at E0 and falls at E(WIDTH+1).
- A 0 on sin during IDLE is always a start bit, even immediately after a frame_err (no resynchronisation hunt).

## Configuration
- SERIAL_FRAME_RX_PARITY_EN defined: PARITY state inserted between DATA and STOP; one even-parity bit expected (XOR of data bits and parity bit = 0); extra output parity_err (1 bit, reset 0) pulses one cycle at the stop-bit edge when parity mismatched; on mismatch q is not updated and valid stays 0, regardless of stop bit; if both stop and parity are bad, both error outputs pulse. Frame is WIDTH+3 cycles.
- Not defined: no PARITY state, no parity_err port, frame is WIDTH+2 cycles.

## Structure
- Shared package: state encoding (IDLE, DATA, STOP, PARITY), line-level constants (idle/stop level 1, start level 0), counter width derived from maximum WIDTH.
- One sub-module: sipo_shift_reg (WIDTH-bit serial-in parallel-out register with shift enable, LSB-first fill); FSM, counter and output registers live in serial_frame_rx.

## Test plan
- Reset then sin held 1 for 20 cycles -> q=0x00, valid/frame_err/busy stay 0.
- WIDTH=8, frame 0, bits of 0xA5 LSB first (1,0,1,0,0,1,0,1), stop 1 -> q=0xA5, valid high exactly one cycle, 9 cycles after start sample.
- Frame of 0x3C with stop bit 0 -> frame_err one cycle, valid 0, q keeps previous 0xA5.
- Two back-to-back frames 0x01 then 0xFF with no idle gap -> two valid pulses 10 cycles apart, q=0x01 then 0xFF.
- r=0 at 4th data bit of a frame, released, then a clean frame 0x5A -> outputs 0 during reset, no error pulse, then q=0x5A with valid.
- PARITY_EN: 0x07 with parity bit 1 -> valid, q=0x07; same with parity bit 0 -> parity_err pulse, q unchanged.
